multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have no parameters; all widths below are fixed.
REQ-002 clk  input  1  rising-edge clock; the single clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 op  input  6  opcode field, instr[31:26], from the instruction register.
REQ-005 zero  input  1  ALU zero flag for the current cycle.
REQ-006 memread  output  1  memory read strobe.
REQ-007 memwrite  output  1  memory write strobe.
REQ-008 iord  output  1  memory-address mux select: 1 = ALUOut, 0 = PC.
REQ-009 memtoreg  output  1  write-data mux select: 1 = MDR, 0 = ALUOut.
REQ-010 regdst  output  1  write-register mux select: 1 = rd, 0 = rt.
REQ-011 regwrite  output  1  register-file write enable.
REQ-012 alusrca  output  1  ALU A mux select: 1 = register A, 0 = PC.
REQ-013 alusrcb  output  2  ALU B 4-input mux select: 00 = B, 01 = constant 1, 10 = imm, 11 = imm (branch offset).
REQ-014 pcsource  output  2  PC 4-input mux select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-015 aluop  output  2  ALU decoder class: 00 = add, 01 = subtract, 10 = funct field.
REQ-016 irwrite  output  4  one-hot byte enables for the instruction register, bit0 = byte 0.
REQ-017 pcen  output  1  PC register enable.

Function
REQ-018 The block SHALL be a Moore FSM with 13 states: FETCH1, FETCH2, FETCH3, FETCH4, DECODE, MEMADR, LBRD, LBWR, SBWR, RTYPEEX, RTYPEWR, BEQEX, JEX.
REQ-019 The state register SHALL update only on rising clk; all outputs SHALL be combinational functions of the current state, plus zero for pcen only.
REQ-020 Transitions SHALL be: FETCH1->FETCH2->FETCH3->FETCH4->DECODE, each unconditional.
REQ-021 From DECODE the next state SHALL be selected by op: 100000 (LB) or 101000 (SB) -> MEMADR; 000000 (R-type) -> RTYPEEX; 000100 (BEQ) -> BEQEX; 000010 (J) -> JEX; any other value -> FETCH1.
REQ-022 From MEMADR the next state SHALL be LBRD if op = 100000, SBWR if op = 101000, and FETCH1 otherwise.
REQ-023 Further transitions SHALL be: LBRD->LBWR, RTYPEEX->RTYPEWR, and LBWR, SBWR, RTYPEWR, BEQEX, JEX -> FETCH1.
REQ-024 Every output not listed for a state SHALL be 0 in that state.
REQ-025 FETCHn (n = 1..4) SHALL drive memread = 1, alusrcb = 01, pcsource = 00, internal pcwrite = 1, and irwrite = 0001, 0010, 0100, 1000 respectively.
REQ-026 DECODE SHALL drive alusrcb = 11; MEMADR SHALL drive alusrca = 1 and alusrcb = 10.
REQ-027 LBRD SHALL drive memread = 1 and iord = 1; LBWR SHALL drive regwrite = 1 and memtoreg = 1; SBWR SHALL drive memwrite = 1 and iord = 1.
REQ-028 RTYPEEX SHALL drive alusrca = 1 and aluop = 10; RTYPEWR SHALL drive regdst = 1 and regwrite = 1.
REQ-029 BEQEX SHALL drive alusrca = 1, aluop = 01, pcsource = 01, and internal pcwritecond = 1.
REQ-030 JEX SHALL drive pcsource = 10 and internal pcwrite = 1.
REQ-031 pcen SHALL equal pcwrite OR (pcwritecond AND zero); a zero toggle outside BEQEX SHALL NOT affect pcen.
REQ-032 Instruction latency SHALL be: LB 8 cycles; SB, R-type 7 cycles; BEQ, J 6 cycles; an undefined op SHALL take 5 cycles and have no register, memory or PC side effect beyond fetch.
REQ-033 irwrite SHALL be one-hot or zero in every state; memread and memwrite SHALL never both be 1.
REQ-034 Unreachable state encodings SHALL return to FETCH1 on the next clk, with all outputs 0 while in them.

Reset
REQ-035 While reset = 1 at a rising clk, the next state SHALL be FETCH1, regardless of the current state or op.
REQ-036 After reset the outputs SHALL be the FETCH1 values: memread = 1, irwrite = 0001, alusrcb = 01, pcen = 1, and all others 0.
REQ-037 Reset asserted mid-instruction (for example in SBWR) SHALL abort the instruction with no further memwrite or regwrite after that edge.
REQ-038 The block SHALL have no asynchronous reset path.

Verification
REQ-039 Reset, then op = 000000 held -> states FETCH1..4, DECODE, RTYPEEX (aluop = 10), RTYPEWR (regdst = regwrite = 1), FETCH1; 7 cycles total.
REQ-040 op = 100000 -> MEMADR, LBRD (memread = iord = 1), LBWR (memtoreg = regwrite = 1); 8 cycles total; op = 101000 -> SBWR with memwrite = 1 and iord = 1.
REQ-041 op = 000100 in BEQEX with zero = 1 -> pcen = 1, pcsource = 01; repeat with zero = 0 -> pcen = 0; in both cases the next state is FETCH1.
REQ-042 op = 000010 -> JEX with pcsource = 10, pcen = 1; op = 111111 -> DECODE then FETCH1, with regwrite = memwrite = 0 throughout.
REQ-043 Assert reset in LBRD -> next cycle is FETCH1 with irwrite = 0001 and LBWR never entered; check irwrite one-hot and memread/memwrite mutual exclusion on every cycle.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and its datapath:
// opcode and zero flag in, mux selects and strobes out.
interface multicycle_ctrl_if;
    logic [5:0] op;
    logic       zero;
    logic       memread;
    logic       memwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsource;
    logic [1:0] aluop;
    logic [3:0] irwrite;
    logic       pcen;

    modport master (
        input  op, zero,
        output memread, memwrite, iord, memtoreg, regdst, regwrite,
               alusrca, alusrcb, pcsource, aluop, irwrite, pcen
    );

    modport slave (
        output op, zero,
        input  memread, memwrite, iord, memtoreg, regdst, regwrite,
               alusrca, alusrcb, pcsource, aluop, irwrite, pcen
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for an 8-bit multicycle MIPS subset: byte-wise fetch,
// decode, then LB / SB / R-type / BEQ / J execution sequences.
module multicycle_ctrl (
    input  logic                clk,
    input  logic                reset,
    multicycle_ctrl_if.master   bus
);

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        FETCH1  = 4'd0,
        FETCH2  = 4'd1,
        FETCH3  = 4'd2,
        FETCH4  = 4'd3,
        DECODE  = 4'd4,
        MEMADR  = 4'd5,
        LBRD    = 4'd6,
        LBWR    = 4'd7,
        SBWR    = 4'd8,
        RTYPEEX = 4'd9,
        RTYPEWR = 4'd10,
        BEQEX   = 4'd11,
        JEX     = 4'd12
    } state_t;

    state_t state;
    state_t state_next;
    logic   pcwrite;
    logic   pcwritecond;

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (reset) state <= FETCH1;
        else       state <= state_next;
    end

    // NOTE: every signal driven here gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = FETCH1;
        case (state)
            FETCH1:  state_next = FETCH2;
            FETCH2:  state_next = FETCH3;
            FETCH3:  state_next = FETCH4;
            FETCH4:  state_next = DECODE;
            DECODE: begin
                case (bus.op)
                    OP_LB, OP_SB: state_next = MEMADR;
                    OP_RTYPE:     state_next = RTYPEEX;
                    OP_BEQ:       state_next = BEQEX;
                    OP_J:         state_next = JEX;
                    default:      state_next = FETCH1;
                endcase
            end
            MEMADR: begin
                if (bus.op == OP_LB)      state_next = LBRD;
                else if (bus.op == OP_SB) state_next = SBWR;
                else                      state_next = FETCH1;
            end
            LBRD:    state_next = LBWR;
            RTYPEEX: state_next = RTYPEWR;
            default: state_next = FETCH1;
        endcase
    end

    always_comb begin
        bus.memread  = 1'b0;
        bus.memwrite = 1'b0;
        bus.iord     = 1'b0;
        bus.memtoreg = 1'b0;
        bus.regdst   = 1'b0;
        bus.regwrite = 1'b0;
        bus.alusrca  = 1'b0;
        bus.alusrcb  = 2'b00;
        bus.pcsource = 2'b00;
        bus.aluop    = 2'b00;
        bus.irwrite  = 4'b0000;
        pcwrite      = 1'b0;
        pcwritecond  = 1'b0;
        case (state)
            FETCH1, FETCH2, FETCH3, FETCH4: begin
                bus.memread = 1'b1;
                bus.alusrcb = 2'b01;
                pcwrite     = 1'b1;
                // Each fetch cycle loads one byte of the 32-bit instruction.
                case (state)
                    FETCH1:  bus.irwrite = 4'b0001;
                    FETCH2:  bus.irwrite = 4'b0010;
                    FETCH3:  bus.irwrite = 4'b0100;
                    default: bus.irwrite = 4'b1000;
                endcase
            end
            DECODE:  bus.alusrcb = 2'b11;
            MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            LBRD: begin
                bus.memread = 1'b1;
                bus.iord    = 1'b1;
            end
            LBWR: begin
                bus.regwrite = 1'b1;
                bus.memtoreg = 1'b1;
            end
            SBWR: begin
                bus.memwrite = 1'b1;
                bus.iord     = 1'b1;
            end
            RTYPEEX: begin
                bus.alusrca = 1'b1;
                bus.aluop   = 2'b10;
            end
            RTYPEWR: begin
                bus.regdst   = 1'b1;
                bus.regwrite = 1'b1;
            end
            BEQEX: begin
                bus.alusrca  = 1'b1;
                bus.aluop    = 2'b01;
                bus.pcsource = 2'b01;
                pcwritecond  = 1'b1;
            end
            JEX: begin
                bus.pcsource = 2'b10;
                pcwrite      = 1'b1;
            end
            default: ;
        endcase
    end

    // zero only matters while a branch is being resolved.
    assign bus.pcen = pcwrite | (pcwritecond & bus.zero);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: an instruction-level model predicts
// every control output from the opcode and the cycle offset within the instruction.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsource;
        logic [1:0] aluop;
        logic [3:0] irwrite;
        logic       pcen;
    } ctl_t;

    localparam logic [5:0] LB  = 6'b100000;
    localparam logic [5:0] SB  = 6'b101000;
    localparam logic [5:0] RT  = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] JMP = 6'b000010;

    // Hand-computed output vectors, field order as in ctl_t.
    localparam ctl_t FETCH1_V  = 18'b1_0_0_0_0_0_0_01_00_00_0001_1;
    localparam ctl_t DECODE_V  = 18'b0_0_0_0_0_0_0_11_00_00_0000_0;
    localparam ctl_t LBRD_V    = 18'b1_0_1_0_0_0_0_00_00_00_0000_0;
    localparam ctl_t SBWR_V    = 18'b0_1_1_0_0_0_0_00_00_00_0000_0;
    localparam ctl_t RTWR_V    = 18'b0_0_0_0_1_1_0_00_00_00_0000_0;
    localparam ctl_t BEQ_T_V   = 18'b0_0_0_0_0_0_1_00_01_01_0000_1;
    localparam ctl_t BEQ_NT_V  = 18'b0_0_0_0_0_0_1_00_01_01_0000_0;
    localparam ctl_t JEX_V     = 18'b0_0_0_0_0_0_0_00_10_00_0000_1;

    logic clk = 1'b0;
    logic reset;
    logic chk_en = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   step = 0;
    ctl_t act;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    assign act = {bus.memread, bus.memwrite, bus.iord, bus.memtoreg, bus.regdst,
                  bus.regwrite, bus.alusrca, bus.alusrcb, bus.pcsource, bus.aluop,
                  bus.irwrite, bus.pcen};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Instruction length in cycles, from opcode alone.
    function automatic int instr_len(input logic [5:0] o);
        case (o)
            LB:      return 8;
            SB, RT:  return 7;
            BEQ, JMP: return 6;
            default: return 5;
        endcase
    endfunction

    // Expected outputs at cycle offset s of an instruction with opcode o.
    function automatic ctl_t exp_ctl(input logic [5:0] o, input int s, input logic z);
        ctl_t e;
        e = '0;
        if (s < 4) begin
            e.memread = 1'b1;
            e.alusrcb = 2'b01;
            e.pcen    = 1'b1;
            e.irwrite = 4'(1 << s);
        end else if (s == 4) begin
            e.alusrcb = 2'b11;
        end else if ((o == LB || o == SB) && s == 5) begin
            e.alusrca = 1'b1;
            e.alusrcb = 2'b10;
        end else if (o == LB && s == 6) begin
            e.memread = 1'b1;
            e.iord    = 1'b1;
        end else if (o == LB && s == 7) begin
            e.regwrite = 1'b1;
            e.memtoreg = 1'b1;
        end else if (o == SB && s == 6) begin
            e.memwrite = 1'b1;
            e.iord     = 1'b1;
        end else if (o == RT && s == 5) begin
            e.alusrca = 1'b1;
            e.aluop   = 2'b10;
        end else if (o == RT && s == 6) begin
            e.regdst   = 1'b1;
            e.regwrite = 1'b1;
        end else if (o == BEQ && s == 5) begin
            e.alusrca  = 1'b1;
            e.aluop    = 2'b01;
            e.pcsource = 2'b01;
            e.pcen     = z;
        end else if (o == JMP && s == 5) begin
            e.pcsource = 2'b10;
            e.pcen     = 1'b1;
        end
        return e;
    endfunction

    // Cycle offset tracker; op is held constant across an instruction.
    always @(posedge clk) begin
        if (reset)                              step <= 0;
        else if (step >= instr_len(bus.op) - 1) step <= 0;
        else                                    step <= step + 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check($sformatf("cycle op=%b step=%0d", bus.op, step),
                  32'(act), 32'(exp_ctl(bus.op, step, bus.zero)));
            check("irwrite_onehot0", 32'($onehot0(act.irwrite)), 32'd1);
            check("rd_wr_excl", 32'(act.memread & act.memwrite), 32'd0);
        end
    end

    // Runs one instruction from FETCH1; optional literal pin and reset injection.
    task automatic run(input logic [5:0] o, input int zmode, input int pin_step,
                       input ctl_t pin_val, input int rst_step);
        bus.op = o;
        for (int i = 0; i < instr_len(o); i++) begin
            bus.zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : zmode[0];
            #1;
            if (i == pin_step)
                check($sformatf("pin op=%b step=%0d", o, i), 32'(act), 32'(pin_val));
            if (i == rst_step) begin
                reset = 1'b1;
                @(posedge clk);
                #1;
                reset = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Counts cycles until the DUT is back in the first fetch cycle.
    task automatic measure(input logic [5:0] o, input int want);
        int n;
        n = 0;
        bus.op = o;
        do begin
            bus.zero = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            n++;
        end while (act.irwrite != 4'b0001 && n < 20);
        check($sformatf("latency op=%b", o), 32'(n), 32'(want));
    endtask

    initial begin
        reset    = 1'b1;
        bus.op   = RT;
        bus.zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("reset_state", 32'(act), 32'(FETCH1_V));
        @(posedge clk);
        #1;
        reset = 1'b0;

        run(RT, 0, 6, RTWR_V, -1);
        run(LB, 1, 6, LBRD_V, -1);
        run(SB, 0, 6, SBWR_V, -1);
        run(BEQ, 1, 5, BEQ_T_V, -1);
        run(BEQ, 0, 5, BEQ_NT_V, -1);
        run(JMP, 0, 5, JEX_V, -1);
        run(6'b111111, -1, 4, DECODE_V, -1);

        measure(LB, 8);
        measure(SB, 7);
        measure(RT, 7);
        measure(BEQ, 6);
        measure(JMP, 6);
        measure(6'b111111, 5);

        // Abort a load in LBRD: next cycle must be the first fetch.
        run(LB, 0, -1, '0, 6);
        check("abort_to_fetch1", 32'(act), 32'(FETCH1_V));
        run(SB, 1, -1, '0, 6);
        check("abort_sb_no_write", 32'(act.memwrite), 32'd0);

        for (int k = 0; k < 300; k++) begin
            logic [5:0] o;
            int         rs;
            case ($urandom_range(0, 5))
                0:       o = LB;
                1:       o = SB;
                2:       o = RT;
                3:       o = BEQ;
                4:       o = JMP;
                default: o = 6'($urandom);
            endcase
            rs = ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, instr_len(o) - 1)) : -1;
            run(o, -1, -1, '0, rs);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
